// File: rtl/alu_pkg.sv
// Shared types for the alu and the logic that feeds it: opcode/compare enums,
// arbiter FSM states and the operand/result bundles latched around the alu.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_NOP
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0,
        CMP_NEQ,
        CMP_LT,
        CMP_GE,
        CMP_LTU,
        CMP_GEU
    } cmp_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        alu_ctrl_t   alu_ctrl;
        cmp_ctrl_t   cmp_ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } alu_op_t;

    typedef struct packed {
        logic [31:0] data;
        logic        cmp;
        logic        zero;
        logic        ovf;
    } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu with a side comparator. Undefined opcodes yield 0,
// undefined compare codes yield a false result.
module alu
    import alu_pkg::*;
(
    input  alu_ctrl_t   alu_ctrl,
    input  cmp_ctrl_t   cmp_ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_do,
    output logic        cmp_result,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[4:0];

    always_comb begin
        alu_do = '0;
        ovf    = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                alu_do = sum;
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                alu_do = diff;
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_XOR: alu_do = a ^ b;
            ALU_OR:  alu_do = a | b;
            ALU_AND: alu_do = a & b;
            ALU_SLL: alu_do = a << shamt;
            ALU_SRL: alu_do = a >> shamt;
            ALU_SRA: alu_do = $signed(a) >>> shamt;
            ALU_NOP: alu_do = '0;
            default: alu_do = '0;
        endcase
    end

    always_comb begin
        cmp_result = 1'b0;
        case (cmp_ctrl)
            CMP_EQ:  cmp_result = (a == b);
            CMP_NEQ: cmp_result = (a != b);
            CMP_LT:  cmp_result = ($signed(a) <  $signed(b));
            CMP_GE:  cmp_result = ($signed(a) >= $signed(b));
            CMP_LTU: cmp_result = (a <  b);
            CMP_GEU: cmp_result = (a >= b);
            default: cmp_result = 1'b0;
        endcase
    end

    assign zero = (alu_do == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N so a non-power-of-two N never yields an invalid index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = IW'((32'(ptr) + 32'(i)) % 32'(N));
                if (!any && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one alu among NUM_REQ valid/ready requesters: round-robin grant,
// one evaluation cycle, then the result is held for its owner until accepted.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][3:0]  req_alu_ctrl,
    input  logic [NUM_REQ-1:0][2:0]  req_cmp_ctrl,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_cmp,
    output logic                     rsp_zero,
    output logic                     rsp_ovf,
    output logic                     busy
);

    localparam int REQ_W = $clog2(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [REQ_W-1:0]     ptr_q, ptr_d;
    logic [REQ_W-1:0]     owner_q, owner_d;
    alu_op_t              op_q, op_d;
    alu_rsp_t             res_q, res_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [REQ_W-1:0]     arb_idx;
    logic                 arb_any;

    logic [31:0]          alu_do;
    logic                 alu_cmp;
    logic                 alu_zero;
    logic                 alu_ovf;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (REQ_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // The alu only ever sees latched operands, so requester inputs may change
    // freely once their request has been accepted.
    alu u_alu (
        .alu_ctrl   (op_q.alu_ctrl),
        .cmp_ctrl   (op_q.cmp_ctrl),
        .a          (op_q.a),
        .b          (op_q.b),
        .alu_do     (alu_do),
        .cmp_result (alu_cmp),
        .zero       (alu_zero),
        .ovf        (alu_ovf)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    owner_d = arb_idx;
                    op_d    = '{alu_ctrl_t'(req_alu_ctrl[arb_idx]),
                                cmp_ctrl_t'(req_cmp_ctrl[arb_idx]),
                                req_a[arb_idx], req_b[arb_idx]};
                    ptr_d   = (arb_idx == REQ_W'(NUM_REQ - 1)) ? '0 : arb_idx + REQ_W'(1);
                    state_d = EXEC;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                res_d                = '{alu_do, alu_cmp, alu_zero, alu_ovf};
                rsp_valid_d          = '0;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = arb_gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q.data;
    assign rsp_cmp   = res_q.cmp;
    assign rsp_zero  = res_q.zero;
    assign rsp_ovf   = res_q.ovf;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scenario bench for alu_share_arbiter with three requesters, checked against
// an arithmetic alu model and a rotating-pointer grant model.
module tb_alu_share_arbiter;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [N-1:0][3:0]   req_alu_ctrl = '0;
    logic [N-1:0][2:0]   req_cmp_ctrl = '0;
    logic [N-1:0][31:0]  req_a = '0;
    logic [N-1:0][31:0]  req_b = '0;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready = '0;
    logic [31:0]         rsp_data;
    logic                rsp_cmp, rsp_zero, rsp_ovf, busy;

    int total = 0;
    int bad   = 0;
    int mdl_ptr = 0;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_ctrl(req_alu_ctrl), .req_cmp_ctrl(req_cmp_ctrl),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cmp(rsp_cmp), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Next requester in rotation from the model pointer; -1 when none pending.
    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void alu_ref(input logic [3:0] c, input logic [2:0] k,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic cm,
                                    output logic z, output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0;
        o  = 1'b0;
        case (c)
            4'd0: s = sa + sb;
            4'd1: s = sa - sb;
            default: s = 0;
        endcase
        case (c)
            4'd0, 4'd1: begin r = s[31:0]; o = (s != longint'($signed(r))); end
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: begin s = sa >>> b[4:0]; r = s[31:0]; end
            default: r = '0;
        endcase
        case (k)
            3'd0: cm = (a == b);
            3'd1: cm = (a != b);
            3'd2: cm = (sa < sb);
            3'd3: cm = (sa >= sb);
            3'd4: cm = (a < b);
            3'd5: cm = (a >= b);
            default: cm = 1'b0;
        endcase
        z = (r == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({rsp_data, rsp_cmp, rsp_zero, rsp_ovf} !== 35'd0) begin
            bad++; $display("FAIL reset_rsp_bus: got %h/%b%b%b want 0", rsp_data, rsp_cmp, rsp_zero, rsp_ovf);
        end
        #3 rst_n = 1'b1;
        mdl_ptr = 0;
    endtask

    task automatic test_single();
        tick();
        req_alu_ctrl[0] = 4'd0; req_cmp_ctrl[0] = 3'd0; req_a[0] = 32'd7; req_b[0] = 32'd5;
        req_valid = 3'b001;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_grant: got %b want 001", req_ready); end
        mdl_ptr = 1;
        tick();
        req_valid = '0; req_a[0] = 32'd99;
        #1;
        total++; if (busy !== 1'b1 || rsp_valid !== '0) begin
            bad++; $display("FAIL single_exec: busy %b rsp_valid %b want 1/000", busy, rsp_valid);
        end
        for (int h = 0; h < 3; h++) begin
            if (h > 0) tick(); else begin tick(); end
            #1;
            total++; if (rsp_valid !== 3'b001 || rsp_data !== 32'd12 || rsp_zero !== 1'b0 || rsp_ovf !== 1'b0) begin
                bad++; $display("FAIL single_rsp_%0d: got v=%b d=%0d z=%b o=%b want 001/12/0/0", h, rsp_valid, rsp_data, rsp_zero, rsp_ovf);
            end
        end
        rsp_ready = 3'b001;
        tick();
        rsp_ready = '0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== '0) begin
            bad++; $display("FAIL single_release: busy %b rsp_valid %b want 0/000", busy, rsp_valid);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] expv;
        int g;
        tick();
        req_valid = 3'b011; rsp_ready = '1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) tick();
            #1;
            expv = '0;
            if (c % 3 == 0) begin
                g = model_grant(3'b011);
                expv[g] = 1'b1;
                mdl_ptr = (g + 1) % N;
            end
            total++; if (req_ready !== expv) begin bad++; $display("FAIL rotation_c%0d: got %b want %b", c, req_ready, expv); end
        end
        req_valid = '0;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_directed();
        int          who [4] = '{1, 1, 0, 0};
        logic [3:0]  ac  [4] = '{4'd1, 4'd1, 4'd7, 4'd12};
        logic [2:0]  cc  [4] = '{3'd0, 3'd2, 3'd0, 3'd6};
        logic [31:0] av  [4] = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'h0000_1234};
        logic [31:0] bv  [4] = '{32'd1, 32'd1, 32'h24, 32'h0000_1234};
        logic [31:0] ed  [4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFF00_0000, 32'd0};
        logic [2:0]  ef  [4] = '{3'b001, 3'b101, 3'b000, 3'b010};
        for (int e = 0; e < 4; e++) begin
            tick();
            req_alu_ctrl[who[e]] = ac[e]; req_cmp_ctrl[who[e]] = cc[e];
            req_a[who[e]] = av[e]; req_b[who[e]] = bv[e];
            req_valid = '0; req_valid[who[e]] = 1'b1;
            #1;
            total++; if (req_ready !== req_valid) begin bad++; $display("FAIL dir%0d_grant: got %b want %b", e, req_ready, req_valid); end
            mdl_ptr = (who[e] + 1) % N;
            tick();
            req_valid = '0;
            tick();
            #1;
            total++; if (rsp_data !== ed[e] || {rsp_cmp, rsp_zero, rsp_ovf} !== ef[e] || rsp_valid[who[e]] !== 1'b1) begin
                bad++; $display("FAIL dir%0d_result: got d=%h czo=%b v=%b want d=%h czo=%b", e, rsp_data, {rsp_cmp, rsp_zero, rsp_ovf}, rsp_valid, ed[e], ef[e]);
            end
            rsp_ready = '0; rsp_ready[who[e]] = 1'b1;
            tick();
            rsp_ready = '0;
        end
    endtask

    task automatic test_resp_hold();
        tick();
        req_alu_ctrl[0] = 4'd0; req_cmp_ctrl[0] = 3'd0; req_a[0] = 32'd1; req_b[0] = 32'd2;
        req_alu_ctrl[1] = 4'd0; req_cmp_ctrl[1] = 3'd0; req_a[1] = 32'd10; req_b[1] = 32'd20;
        mdl_ptr = 0;
        req_valid = 3'b001;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL hold_grant0: got %b want 001", req_ready); end
        mdl_ptr = 1;
        tick();
        req_valid = 3'b010; rsp_ready = 3'b010;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            total++; if (rsp_valid !== 3'b001 || req_ready !== '0 || busy !== 1'b1) begin
                bad++; $display("FAIL hold_k%0d: got v=%b rdy=%b busy=%b want 001/000/1", k, rsp_valid, req_ready, busy);
            end
        end
        rsp_ready = 3'b001;
        tick();
        rsp_ready = '0;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL hold_grant1: got %b want 010", req_ready); end
        mdl_ptr = 2;
        tick();
        req_valid = '0;
        tick();
        #1;
        total++; if (rsp_valid !== 3'b010 || rsp_data !== 32'd30) begin
            bad++; $display("FAIL hold_rsp1: got v=%b d=%0d want 010/30", rsp_valid, rsp_data);
        end
        rsp_ready = 3'b010;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] mask, expv;
        logic [31:0]  ed;
        logic         ec, ez, eo;
        int           g, hold;
        for (int it = 0; it < 60; it++) begin
            tick();
            mask = N'($urandom_range(0, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                req_alu_ctrl[r] = 4'($urandom_range(0, 15));
                req_cmp_ctrl[r] = 3'($urandom_range(0, 7));
                req_a[r] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                req_b[r] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            req_valid = mask;
            #1;
            g = model_grant(mask);
            expv = '0;
            if (g >= 0) expv[g] = 1'b1;
            total++; if (req_ready !== expv) begin bad++; $display("FAIL rand%0d_grant: got %b want %b (mask %b)", it, req_ready, expv, mask); end
            if (g < 0) continue;
            mdl_ptr = (g + 1) % N;
            alu_ref(req_alu_ctrl[g], req_cmp_ctrl[g], req_a[g], req_b[g], ed, ec, ez, eo);
            tick();
            req_valid = '0;
            for (int r = 0; r < N; r++) begin req_a[r] = $urandom; req_b[r] = $urandom; end
            tick();
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
                #1;
                total++; if (rsp_valid !== expv || rsp_data !== ed || rsp_cmp !== ec || rsp_zero !== ez || rsp_ovf !== eo) begin
                    bad++; $display("FAIL rand%0d_rsp%0d: got v=%b d=%h c=%b z=%b o=%b want v=%b d=%h c=%b z=%b o=%b",
                                    it, h, rsp_valid, rsp_data, rsp_cmp, rsp_zero, rsp_ovf, expv, ed, ec, ez, eo);
                end
                rsp_ready = N'($urandom) & ~expv;
                if (h == hold) rsp_ready = rsp_ready | expv;
                tick();
            end
            rsp_ready = '0;
            #1;
            total++; if (busy !== 1'b0 || rsp_valid !== '0) begin
                bad++; $display("FAIL rand%0d_release: busy %b v %b want 0/000", it, busy, rsp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        req_alu_ctrl[0] = 4'd0; req_a[0] = 32'd3; req_b[0] = 32'd4; req_cmp_ctrl[0] = 3'd0;
        mdl_ptr = 0;
        req_valid = 3'b001;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rstmid_grant: got %b want 001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_exec_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || rsp_data !== '0) begin
            bad++; $display("FAIL rstmid_async: busy %b v %b rdy %b d %h want all 0", busy, rsp_valid, req_ready, rsp_data);
        end
        mdl_ptr = 0;
        #2 rst_n = 1'b1;
        tick();
        req_alu_ctrl[1] = 4'd0; req_a[1] = 32'd1; req_b[1] = 32'd1;
        req_valid = 3'b011;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rstmid_ptr: got %b want 001", req_ready); end
        mdl_ptr = 1;
        tick();
        req_valid = '0;
        tick();
        #1;
        total++; if (rsp_valid !== 3'b001 || rsp_data !== 32'd7) begin
            bad++; $display("FAIL rstmid_rsp: got v=%b d=%0d want 001/7", rsp_valid, rsp_data);
        end
        rsp_ready = 3'b001;
        tick();
        rsp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_directed();
        test_resp_hold();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
